// File: rtl/mem_pkg.sv
// Shared types and constants for the mainMem arbiter: FSM states, access-size
// encodings, memory window and the window address check.
package mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_RMW_WR = 3'd3,
      ST_WRITE  = 3'd4
   } state_t;

   localparam logic [1:0]  SZ_BYTE       = 2'b00;
   localparam logic [1:0]  SZ_HALF       = 2'b01;
   localparam logic [1:0]  SZ_WORD       = 2'b10;
   localparam logic [31:0] START_ADDRESS = 32'h8002_0000;
   localparam int          MEM_SIZE      = 1048576;

   // The base itself is rejected; the whole 4-byte word must fit in the window.
   function automatic logic addr_ok(input logic [31:0] i_addr,
                                    input logic [31:0] i_base,
                                    input logic [31:0] i_size);
      logic [31:0] w_off;
      w_off = i_addr - i_base;
      return (i_addr > i_base) && (w_off <= (i_size - 32'd4));
   endfunction

endpackage

// File: rtl/store_merge.sv
// Big-endian sub-word store merge and load extract/extend. Byte 0 of the
// memory word is its most significant byte.
module store_merge #(
   parameter int DATA_SIZE = 32
) (
   input  logic [DATA_SIZE-1:0] i_old_word,
   input  logic [DATA_SIZE-1:0] i_wdata,
   input  logic [1:0]           i_size,
   input  logic                 i_unsigned,
   output logic [DATA_SIZE-1:0] o_merged,
   output logic [DATA_SIZE-1:0] o_load
);
   import mem_pkg::*;

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_fill;

   assign w_byte = i_old_word[DATA_SIZE-1 -: 8];
   assign w_half = i_old_word[DATA_SIZE-1 -: 16];

   // Store data is right-justified; it lands in the leading bytes of the word.
   always_comb begin
      o_merged = i_old_word;
      case (i_size)
         SZ_BYTE: o_merged[DATA_SIZE-1 -: 8]  = i_wdata[7:0];
         SZ_HALF: o_merged[DATA_SIZE-1 -: 16] = i_wdata[15:0];
         default: o_merged = i_wdata;
      endcase
   end

   // Load result is right-justified and sign- or zero-extended.
   always_comb begin
      o_load = i_old_word;
      w_fill = 1'b0;
      case (i_size)
         SZ_BYTE: begin
            w_fill = i_unsigned ? 1'b0 : w_byte[7];
            o_load = {{(DATA_SIZE-8){w_fill}}, w_byte};
         end
         SZ_HALF: begin
            w_fill = i_unsigned ? 1'b0 : w_half[15];
            o_load = {{(DATA_SIZE-16){w_fill}}, w_half};
         end
         default: o_load = i_old_word;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing single-ported mainMem between the fetch (I)
// and load/store (D) ports; sub-word stores are done as read-modify-write.
module mem_arbiter #(
   parameter int                      ADDRESS_SIZE  = 32,
   parameter int                      DATA_SIZE     = 32,
   parameter int                      MEM_SIZE      = mem_pkg::MEM_SIZE,
   parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = mem_pkg::START_ADDRESS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_req,
   input  logic [ADDRESS_SIZE-1:0] i_addr,
   output logic                    i_gnt,
   output logic                    i_rvalid,
   output logic [DATA_SIZE-1:0]    i_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [1:0]              d_size,
   input  logic                    d_unsigned,
   input  logic [ADDRESS_SIZE-1:0] d_addr,
   input  logic [DATA_SIZE-1:0]    d_wdata,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_SIZE-1:0]    d_rdata,
   output logic                    err,
   output logic                    busy,
   output logic                    mem_en,
   output logic                    mem_wren,
   output logic [ADDRESS_SIZE-1:0] mem_addr,
   output logic [DATA_SIZE-1:0]    mem_din,
   output logic [1:0]              mem_acc_size,
   input  logic [DATA_SIZE-1:0]    mem_dout
);
   import mem_pkg::*;

   state_t                  r_state;
   logic                    r_last_d;
   logic                    r_own_d;
   logic [1:0]              r_size;
   logic                    r_unsigned;
   logic [DATA_SIZE-1:0]    r_wdata;
   logic                    r_i_rvalid;
   logic [DATA_SIZE-1:0]    r_i_rdata;
   logic                    r_d_rvalid;
   logic [DATA_SIZE-1:0]    r_d_rdata;
   logic                    r_err;
   logic                    r_mem_en;
   logic                    r_mem_wren;
   logic [ADDRESS_SIZE-1:0] r_mem_addr;
   logic [DATA_SIZE-1:0]    r_mem_din;
   logic [1:0]              r_mem_acc_size;

   logic                    w_idle;
   logic                    w_grant_d;
   logic                    w_grant_i;
   logic [ADDRESS_SIZE-1:0] w_acc_addr;
   logic                    w_acc_ok;
   logic [DATA_SIZE-1:0]    w_merged;
   logic [DATA_SIZE-1:0]    w_load;

   // Grants are combinational so a request is accepted in the cycle it is seen.
   assign w_idle     = (r_state == ST_IDLE) && !rst;
   assign w_grant_d  = w_idle && d_req && (!i_req || !r_last_d);
   assign w_grant_i  = w_idle && i_req && !w_grant_d;
   assign w_acc_addr = w_grant_d ? d_addr : i_addr;
   assign w_acc_ok   = addr_ok(w_acc_addr, START_ADDRESS, 32'(MEM_SIZE));

   store_merge #(.DATA_SIZE(DATA_SIZE)) u_store_merge (
      .i_old_word (mem_dout),
      .i_wdata    (r_wdata),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_merged   (w_merged),
      .o_load     (w_load)
   );

   // Sequencer: state, request payload, memory drive and response pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_last_d       <= 1'b0;
         r_own_d        <= 1'b0;
         r_size         <= 2'b00;
         r_unsigned     <= 1'b0;
         r_wdata        <= '0;
         r_i_rvalid     <= 1'b0;
         r_i_rdata      <= '0;
         r_d_rvalid     <= 1'b0;
         r_d_rdata      <= '0;
         r_err          <= 1'b0;
         r_mem_en       <= 1'b0;
         r_mem_wren     <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_din      <= '0;
         r_mem_acc_size <= 2'b00;
      end else begin
         r_mem_acc_size <= SZ_WORD;
         r_i_rvalid     <= 1'b0;
         r_d_rvalid     <= 1'b0;
         r_err          <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_i || w_grant_d) begin
                  r_last_d   <= w_grant_d;
                  r_own_d    <= w_grant_d;
                  r_size     <= w_grant_d ? d_size : SZ_WORD;
                  r_unsigned <= d_unsigned;
                  r_wdata    <= d_wdata;
                  if (!w_acc_ok) begin
                     r_err <= 1'b1;
                     if (w_grant_d) begin
                        r_d_rvalid <= 1'b1;
                        r_d_rdata  <= '0;
                     end else begin
                        r_i_rvalid <= 1'b1;
                        r_i_rdata  <= '0;
                     end
                  end else begin
                     r_mem_en   <= 1'b1;
                     r_mem_addr <= w_acc_addr;
                     if (!w_grant_d || !d_we) begin
                        r_mem_wren <= 1'b0;
                        r_state    <= ST_READ;
                     end else if ((d_size == SZ_BYTE) || (d_size == SZ_HALF)) begin
                        r_mem_wren <= 1'b0;
                        r_state    <= ST_RMW_RD;
                     end else begin
                        r_mem_wren <= 1'b1;
                        r_mem_din  <= d_wdata;
                        r_state    <= ST_WRITE;
                     end
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_READ: begin
               r_mem_en <= 1'b0;
               r_state  <= ST_IDLE;
               if (r_own_d) begin
                  r_d_rvalid <= 1'b1;
                  r_d_rdata  <= w_load;
               end else begin
                  r_i_rvalid <= 1'b1;
                  r_i_rdata  <= w_load;
               end
            end
            ST_RMW_RD: begin
               r_mem_wren <= 1'b1;
               r_mem_din  <= w_merged;
               r_state    <= ST_RMW_WR;
            end
            ST_RMW_WR, ST_WRITE: begin
               r_mem_en   <= 1'b0;
               r_mem_wren <= 1'b0;
               r_d_rvalid <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_mem_en   <= 1'b0;
               r_mem_wren <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_gnt        = w_grant_i;
   assign d_gnt        = w_grant_d;
   assign i_rvalid     = r_i_rvalid;
   assign i_rdata      = r_i_rdata;
   assign d_rvalid     = r_d_rvalid;
   assign d_rdata      = r_d_rdata;
   assign err          = r_err;
   assign busy         = (r_state != ST_IDLE);
   assign mem_en       = r_mem_en;
   assign mem_wren     = r_mem_wren;
   assign mem_addr     = r_mem_addr;
   assign mem_din      = r_mem_din;
   assign mem_acc_size = r_mem_acc_size;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed big-endian mainMem
// model (reads on negedge, writes on posedge).
module tb_mem_arbiter;

   localparam logic [31:0] BASE = 32'h8002_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req, d_we, d_unsigned;
   logic [1:0]  d_size;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        err, busy, mem_en, mem_wren;
   logic [31:0] mem_addr, mem_din;
   logic [1:0]  mem_acc_size;
   logic [31:0] mem_dout = 32'd0;

   logic [7:0]  mem [0:1048575];
   logic        pl_we = 1'b0;
   logic [31:0] pl_addr = 32'd0;
   logic [31:0] pl_data = 32'd0;
   int          en_cnt = 0;
   int          wr_cnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          snap;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .err(err), .busy(busy), .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_acc_size(mem_acc_size), .mem_dout(mem_dout)
   );

   function automatic logic [19:0] moff(input logic [31:0] a);
      logic [31:0] t;
      t = a - BASE;
      return t[19:0];
   endfunction

   function automatic logic [31:0] mrd(input logic [31:0] a);
      logic [19:0] o;
      o = moff(a);
      return {mem[o], mem[o + 20'd1], mem[o + 20'd2], mem[o + 20'd3]};
   endfunction

   always @(negedge clk) begin
      if (mem_en && !mem_wren) mem_dout <= mrd(mem_addr);
   end

   always @(posedge clk) begin
      if (pl_we) begin
         mem[moff(pl_addr)]         <= pl_data[31:24];
         mem[moff(pl_addr) + 20'd1] <= pl_data[23:16];
         mem[moff(pl_addr) + 20'd2] <= pl_data[15:8];
         mem[moff(pl_addr) + 20'd3] <= pl_data[7:0];
      end else if (mem_en && mem_wren) begin
         mem[moff(mem_addr)]         <= mem_din[31:24];
         mem[moff(mem_addr) + 20'd1] <= mem_din[23:16];
         mem[moff(mem_addr) + 20'd2] <= mem_din[15:8];
         mem[moff(mem_addr) + 20'd3] <= mem_din[7:0];
      end
      if (mem_en) en_cnt <= en_cnt + 1;
      if (mem_en && mem_wren) wr_cnt <= wr_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      step();
      pl_we   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      #1;
      check_eq("rst_outs_zero", {31'd0, |{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               err, busy, mem_en, mem_wren, mem_addr, mem_din, mem_acc_size}}, 32'd0);
      rst = 1'b0;
   endtask

   // Presents a D request in cycle 0, checks the grant, returns in cycle 1.
   task automatic d_start(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
      d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
      #1;
      check_eq({tag, "_dgnt"}, {31'd0, d_gnt}, 32'd1);
      step();
      d_req = 1'b0;
      #1;
   endtask

   task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] exp);
      d_start(tag, 1'b0, sz, uns, a, 32'd0);
      step();
      #1;
      check_eq({tag, "_rvalid"}, {31'd0, d_rvalid}, 32'd1);
      check_eq({tag, "_rdata"}, d_rdata, exp);
      step();
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; i_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0;
      d_addr = 32'd0; d_wdata = 32'd0;
      preload(32'h8002_0004, 32'h1234_5678);
      preload(32'h8002_0010, 32'hCAFE_BABE);
      preload(32'h8002_0030, 32'h5566_7788);
      preload(32'h8011_FFFC, 32'hA1B2_C3D4);
      do_reset();

      // fetch: gnt cycle 0, busy cycle 1 only, rvalid cycle 2
      i_req = 1'b1; i_addr = 32'h8002_0004;
      #1;
      check_eq("f_igt", {31'd0, i_gnt}, 32'd1);
      check_eq("f_dgt", {31'd0, d_gnt}, 32'd0);
      check_eq("f_busy0", {31'd0, busy}, 32'd0);
      step(); i_req = 1'b0; #1;
      check_eq("f_busy1", {31'd0, busy}, 32'd1);
      check_eq("f_en1", {30'd0, mem_en, mem_wren}, 32'd2);
      check_eq("f_addr", mem_addr, 32'h8002_0004);
      check_eq("f_acc", {30'd0, mem_acc_size}, 32'd2);
      check_eq("f_rv1", {31'd0, i_rvalid}, 32'd0);
      step(); #1;
      check_eq("f_rv2", {31'd0, i_rvalid}, 32'd1);
      check_eq("f_rdata", i_rdata, 32'h1234_5678);
      check_eq("f_busy2", {31'd0, busy}, 32'd0);
      check_eq("f_en2", {31'd0, mem_en}, 32'd0);
      step(); #1;
      check_eq("f_rv3", {31'd0, i_rvalid}, 32'd0);

      // byte store as read-modify-write
      preload(32'h8002_0005, 32'h1122_3344);
      d_start("sb", 1'b1, 2'b00, 1'b0, 32'h8002_0005, 32'h1234_56AB);
      check_eq("sb_c1", {30'd0, mem_en, mem_wren}, 32'd2);
      step(); #1;
      check_eq("sb_c2", {30'd0, mem_en, mem_wren}, 32'd3);
      check_eq("sb_din", mem_din, 32'hAB22_3344);
      check_eq("sb_rv2", {31'd0, d_rvalid}, 32'd0);
      step(); #1;
      check_eq("sb_rv3", {31'd0, d_rvalid}, 32'd1);
      check_eq("sb_en3", {31'd0, mem_en}, 32'd0);
      check_eq("sb_mem", mrd(32'h8002_0005), 32'hAB22_3344);
      step();

      // half store and word store (size 11 acts as word)
      d_start("sh", 1'b1, 2'b01, 1'b0, 32'h8002_0010, 32'h9999_BEEF);
      step(); #1;
      check_eq("sh_din", mem_din, 32'hBEEF_BABE);
      step(); #1;
      check_eq("sh_rv3", {31'd0, d_rvalid}, 32'd1);
      check_eq("sh_mem", mrd(32'h8002_0010), 32'hBEEF_BABE);
      step();
      d_start("sw", 1'b1, 2'b11, 1'b0, 32'h8002_0020, 32'hDEAD_BEEF);
      check_eq("sw_c1", {30'd0, mem_en, mem_wren}, 32'd3);
      check_eq("sw_din", mem_din, 32'hDEAD_BEEF);
      step(); #1;
      check_eq("sw_rv2", {31'd0, d_rvalid}, 32'd1);
      check_eq("sw_mem", mrd(32'h8002_0020), 32'hDEAD_BEEF);
      step();

      // loads with sign/zero extension
      preload(32'h8002_0008, 32'h80FF_FFFF);
      do_load("lb_s", 2'b00, 1'b0, 32'h8002_0008, 32'hFFFF_FF80);
      do_load("lb_u", 2'b00, 1'b1, 32'h8002_0008, 32'h0000_0080);
      do_load("lh_s", 2'b01, 1'b0, 32'h8002_0008, 32'hFFFF_80FF);
      do_load("lh_u", 2'b01, 1'b1, 32'h8002_0008, 32'h0000_80FF);
      do_load("lw", 2'b10, 1'b0, 32'h8002_0008, 32'h80FF_FFFF);
      do_load("l_top", 2'b10, 1'b0, 32'h8011_FFFC, 32'hA1B2_C3D4);

      // rejected addresses: err pulse, no memory access, rdata cleared
      snap = en_cnt;
      d_start("e_base", 1'b0, 2'b10, 1'b0, 32'h8002_0000, 32'd0);
      check_eq("e_base_rv", {30'd0, d_rvalid, err}, 32'd3);
      check_eq("e_base_rdata", d_rdata, 32'd0);
      check_eq("e_base_busy", {30'd0, busy, mem_en}, 32'd0);
      step(); #1;
      check_eq("e_base_err1", {31'd0, err}, 32'd0);
      d_start("e_top", 1'b1, 2'b00, 1'b0, 32'h8011_FFFD, 32'h0000_0055);
      check_eq("e_top_rv", {30'd0, d_rvalid, err}, 32'd3);
      check_eq("e_top_noen", en_cnt - snap, 32'd0);
      step();
      i_req = 1'b1; i_addr = 32'h7FFF_FFFC;
      #1;
      check_eq("e_f_gnt", {31'd0, i_gnt}, 32'd1);
      step(); i_req = 1'b0; #1;
      check_eq("e_f_rv", {30'd0, i_rvalid, err}, 32'd3);
      check_eq("e_f_rdata", i_rdata, 32'd0);
      check_eq("e_f_noen", en_cnt - snap, 32'd0);
      step();

      // reset during RMW_RD aborts without writing
      snap = wr_cnt;
      d_start("r", 1'b1, 2'b00, 1'b0, 32'h8002_0030, 32'h0000_00EE);
      check_eq("r_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      step(); #1;
      check_eq("r_outs_zero", {31'd0, |{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               err, busy, mem_en, mem_wren, mem_addr, mem_din, mem_acc_size}}, 32'd0);
      rst = 1'b0;
      step(); #1;
      check_eq("r_norv", {30'd0, d_rvalid, mem_en}, 32'd0);
      check_eq("r_mem", mrd(32'h8002_0030), 32'h5566_7788);
      check_eq("r_nowr", wr_cnt - snap, 32'd0);

      // both ports held high from reset: D, I, D, I
      i_req = 1'b1; i_addr = 32'h8002_0004;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h8002_0008;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         #1;
         check_eq($sformatf("alt_d%0d", c), {31'd0, d_gnt}, {31'd0, (c % 4) == 0});
         check_eq($sformatf("alt_i%0d", c), {31'd0, i_gnt}, {31'd0, (c % 4) == 2});
         step();
      end
      i_req = 1'b0; d_req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
